// File: rtl/acc_pkg.sv
// Shared accelerator constants: IFM beat width, parser burst length and
// the FIFO pointer-width helper (address bits plus one wrap bit).
package acc_pkg;

  localparam int IFM_DATA_WIDTH = 512;
  localparam int IFM_BURST_LEN  = 9;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO: wrap-bit pointers, registered level.
// Ports: clk, flush (sync empty), wr_en/wdata, rd_en, rdata, full, empty, level.
module sync_fifo_fwft
  import acc_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 32,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wdata,
  input  logic          rd_en,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] level
);

  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  // Head is masked while empty so fm reads 0 after reset/flush.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: level <= level + 1'b1;
        pop && !push: level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ifm_prefetch_fifo.sv
// IFM prefetch FIFO: AXIS slave in, FWFT fm out, burst_ready, sticky underflow.
// Optional IFM_PREFETCH_PERF_CNT_EN adds stall_cnt / starve_cnt outputs.
module ifm_prefetch_fifo
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = IFM_DATA_WIDTH,
  parameter int DEPTH      = 32,
  parameter int BURST_LEN  = IFM_BURST_LEN,
  parameter int LVL_W      = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  input_req,
  output logic [DATA_WIDTH-1:0] fm,
  output logic                  fm_last,
  output logic                  fm_valid,
  output logic                  burst_ready,
  output logic [LVL_W-1:0]      level,
  output logic                  underflow_err
`ifdef IFM_PREFETCH_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           starve_cnt
`endif
);

  logic                flush;
  logic                full;
  logic                empty;
  logic [DATA_WIDTH:0] head;

  // rst and clear both flush; a push/pop in a flush cycle is dropped.
  assign flush = rst | clear;

  sync_fifo_fwft #(
    .W     (DATA_WIDTH + 1),
    .DEPTH (DEPTH),
    .PW    (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .flush (flush),
    .wr_en (s_axis_tvalid),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .rd_en (input_req),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign s_axis_tready = ~full;
  assign fm_valid      = ~empty;
  assign fm            = head[DATA_WIDTH-1:0];
  assign fm_last       = head[DATA_WIDTH];
  assign burst_ready   = level >= LVL_W'(BURST_LEN);

  always_ff @(posedge clk) begin
    if (flush) begin
      underflow_err <= 1'b0;
    end else if (input_req && empty) begin
      underflow_err <= 1'b1;
    end
  end

`ifdef IFM_PREFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (flush) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (s_axis_tvalid && full && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (input_req && empty && starve_cnt != '1)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifm_prefetch_fifo.sv
// Self-checking bench for ifm_prefetch_fifo against a queue-based model.
// Directed scenarios followed by a randomized push/pop/clear run.
module tb_ifm_prefetch_fifo;

  localparam int DW = 512;
  localparam int DEPTH = 32;
  localparam int BL = 9;
  localparam int LW = 6;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          input_req = 1'b0;
  logic [DW-1:0] fm;
  logic          fm_last;
  logic          fm_valid;
  logic          burst_ready;
  logic [LW-1:0] level;
  logic          underflow_err;
`ifdef IFM_PREFETCH_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   starve_cnt;
`endif

  beat_t q[$];
  bit    m_uf;
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  ifm_prefetch_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .BURST_LEN  (BL),
    .LVL_W      (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .input_req     (input_req),
    .fm            (fm),
    .fm_last       (fm_last),
    .fm_valid      (fm_valid),
    .burst_ready   (burst_ready),
    .level         (level),
    .underflow_err (underflow_err)
`ifdef IFM_PREFETCH_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .starve_cnt    (starve_cnt)
`endif
  );

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: apply inputs, update the model at the edge, settle 1 time unit.
  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic l, input logic r,
                       input logic c, input logic rs);
    bit do_push;
    bit do_pop;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    input_req     = r;
    clear         = c;
    rst           = rs;
    @(posedge clk);
    if (rs || c) begin
      q.delete();
      m_uf = 1'b0;
    end else begin
      do_push = v && (q.size() < DEPTH);
      do_pop  = r && (q.size() > 0);
      if (r && q.size() == 0) m_uf = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{last: l, data: d});
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    n_vec++;
    if (s_axis_tready !== 1'b1 || fm_valid !== 1'b0 ||
        burst_ready !== 1'b0 || underflow_err !== 1'b0 ||
        fm_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: rdy=%b fv=%b br=%b uf=%b fl=%b want 1 0 0 0 0",
               s_axis_tready, fm_valid, burst_ready, underflow_err, fm_last);
    end
    n_vec++;
    if (level !== '0 || fm !== '0) begin
      n_err++;
      $display("FAIL reset_level_fm: level=%0d fm_nz=%b want 0 0",
               level, |fm);
    end
  endtask

  task automatic test_burst_fill();
    for (int i = 0; i < BL; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (level !== LW'(i + 1) || burst_ready !== (i + 1 >= BL)) begin
        n_err++;
        $display("FAIL fill_%0d: level=%0d br=%b want %0d %b",
                 i, level, burst_ready, i + 1, (i + 1 >= BL));
      end
    end
    n_vec++;
    if (fm !== DW'(0) || fm_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fill_head: fm=%0h fv=%b want 0 1", fm[31:0], fm_valid);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < BL; i++) begin
      n_vec++;
      if (fm !== DW'(i) || fm_valid !== 1'b1) begin
        n_err++;
        $display("FAIL drain_%0d: fm=%0h fv=%b want %0h 1",
                 i, fm[31:0], fm_valid, i);
      end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    idle();
    n_vec++;
    if (level !== '0 || fm_valid !== 1'b0 || underflow_err !== 1'b0) begin
      n_err++;
      $display("FAIL drain_end: level=%0d fv=%b uf=%b want 0 0 0",
               level, fm_valid, underflow_err);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, rand_data(), 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (s_axis_tready !== 1'b0 || level !== LW'(DEPTH)) begin
      n_err++;
      $display("FAIL full: rdy=%b level=%0d want 0 %0d", s_axis_tready, level, DEPTH);
    end
    drive(1'b1, rand_data(), 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (s_axis_tready !== 1'b1 || level !== LW'(DEPTH - 1)) begin
      n_err++;
      $display("FAIL full_pop: rdy=%b level=%0d want 1 %0d",
               s_axis_tready, level, DEPTH - 1);
    end
    drive(1'b1, rand_data(), 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (s_axis_tready !== 1'b0 || level !== LW'(DEPTH)) begin
      n_err++;
      $display("FAIL full_33rd: rdy=%b level=%0d want 0 %0d",
               s_axis_tready, level, DEPTH);
    end
    while (q.size() > 0) begin
      n_vec++;
      if (fm !== q[0].data || fm_last !== q[0].last) begin
        n_err++;
        $display("FAIL full_drain: fm=%0h fl=%b want %0h %b",
                 fm[31:0], fm_last, q[0].data[31:0], q[0].last);
      end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) drive(1'b1, rand_data(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      n_vec++;
      if (fm !== q[0].data) begin
        n_err++;
        $display("FAIL b2b_data_%0d: fm=%0h want %0h", i, fm[31:0], q[0].data[31:0]);
      end
      drive(1'b1, rand_data(), 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (level !== LW'(3)) begin
        n_err++;
        $display("FAIL b2b_level_%0d: level=%0d want 3", i, level);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    n_vec++;
    if (underflow_err !== 1'b1 || level !== '0) begin
      n_err++;
      $display("FAIL underflow_sticky: uf=%b level=%0d want 1 0", underflow_err, level);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (underflow_err !== 1'b0 || level !== '0) begin
      n_err++;
      $display("FAIL underflow_clear: uf=%b level=%0d want 0 0", underflow_err, level);
    end
  endtask

  task automatic test_tlast_rst();
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(i), i == 4, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (level !== '0 || s_axis_tready !== 1'b1 || fm_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst: level=%0d rdy=%b fv=%b want 0 1 0",
               level, s_axis_tready, fm_valid);
    end
    for (int i = 0; i < 6; i++) drive(1'b1, DW'(i), i == 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (fm !== DW'(i) || fm_last !== (i == 4)) begin
        n_err++;
        $display("FAIL tlast_%0d: fm=%0h fl=%b want %0h %b",
                 i, fm[31:0], fm_last, i, (i == 4));
      end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic v, r, c, l;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 2);
      l = $urandom_range(0, 1);
      drive(v, rand_data(), l, r, c, 1'b0);
      n_vec++;
      if (level !== LW'(q.size()) || fm_valid !== (q.size() != 0) ||
          s_axis_tready !== (q.size() < DEPTH) ||
          burst_ready !== (q.size() >= BL) || underflow_err !== m_uf) begin
        n_err++;
        $display("FAIL rand_ctl_%0d: lvl=%0d fv=%b rdy=%b br=%b uf=%b want lvl=%0d uf=%b",
                 i, level, fm_valid, s_axis_tready, burst_ready,
                 underflow_err, q.size(), m_uf);
      end
      if (q.size() != 0) begin
        n_vec++;
        if (fm !== q[0].data || fm_last !== q[0].last) begin
          n_err++;
          $display("FAIL rand_head_%0d: fm=%0h fl=%b want %0h %b",
                   i, fm[31:0], fm_last, q[0].data[31:0], q[0].last);
        end
      end
    end
  endtask

  initial begin
    m_uf = 1'b0;
    test_reset();
    test_burst_fill();
    test_drain();
    test_full();
    test_back_to_back();
    test_underflow();
    test_tlast_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
